// File: rtl/proc_run_controller_pkg.sv
// Shared types and default widths for the processor run controller.
package proc_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int CYC_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_e;

    // Loader owns the memory port in these two states.
    function automatic logic is_load_phase(input run_state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD);
    endfunction

    // Core is out of reset in these three states.
    function automatic logic core_released(input run_state_e s);
        return (s == ST_RUN) || (s == ST_DONE) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/proc_run_controller_if.sv
// Loader, core and memory buses around the run controller.
// slave = controller side, master = environment (loader/core/memory) side.
interface proc_run_controller_if import proc_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic [DATA_W-1:0] core_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        input  core_req, core_we, core_addr, core_wdata,
        input  mem_rdata,
        output ld_ready, core_gnt, core_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        output core_req, core_we, core_addr, core_wdata,
        output mem_rdata,
        input  ld_ready, core_gnt, core_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/proc_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear together with enable loads 1 so the clearing event is itself counted.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = en_i ? W'(1) : '0;
        else if (en_i && (cnt_q != MAX))
            cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_run_controller.sv
// Run controller: arbitrates the unified memory port between the program
// loader and the core, sequences core reset, watchdog and completion status.
module proc_run_controller import proc_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CYC_W  = CYC_W_DEF
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    proc_run_controller_if.slave bus,
    input  logic                 start,
    input  logic                 clear,
    input  logic [CYC_W-1:0]     watchdog_limit,
    input  logic                 core_halted,
    output logic                 core_reset_n,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CYC_W-1:0]     cycle_count,
    output logic [ADDR_W:0]      load_count
);

    localparam logic [ADDR_W:0] LD_MAX = {1'b1, {ADDR_W{1'b0}}};

    run_state_e state_q, state_d;
    logic       core_rst_n_q;
    logic       ld_acc;
    logic       wd_hit;

    // Reset gates ready so nothing reaches memory while rst_n is low.
    assign bus.ld_ready = rst_n & is_load_phase(state_q);
    assign ld_acc       = bus.ld_valid & bus.ld_ready;
    assign wd_hit       = (watchdog_limit != '0) &&
                          (cycle_count == watchdog_limit - CYC_W'(1));

    // Next-state logic; a loader beat outranks start in IDLE, halt outranks watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_acc)     state_d = bus.ld_last ? ST_IDLE : ST_LOAD;
                else if (start) state_d = ST_RUN;
            end
            ST_LOAD:    if (ld_acc && bus.ld_last) state_d = ST_IDLE;
            ST_RUN: begin
                if (core_halted) state_d = ST_DONE;
                else if (wd_hit) state_d = ST_TIMEOUT;
            end
            ST_DONE,
            ST_TIMEOUT: if (clear) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and registered core reset; reset drops the core asynchronously.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= core_released(state_d);
        end
    end

    // Memory port mux; core requests outside RUN are simply dropped.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                bus.mem_en    = ld_acc;
                bus.mem_we    = ld_acc;
                bus.mem_addr  = bus.ld_addr;
                bus.mem_wdata = bus.ld_data;
            end
            ST_RUN: begin
                bus.mem_en    = bus.core_req;
                bus.mem_we    = bus.core_we;
                bus.mem_addr  = bus.core_addr;
                bus.mem_wdata = bus.core_wdata;
            end
            default: ;
        endcase
    end

    assign bus.core_rdata = bus.mem_rdata;
    assign bus.core_gnt   = (state_q == ST_RUN);
    assign core_reset_n   = core_rst_n_q;
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign timeout        = (state_q == ST_TIMEOUT);

    sat_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk   (clk1),
        .rst_n (rst_n),
        .clr_i ((state_q == ST_IDLE) && start && !ld_acc),
        .en_i  (state_q == ST_RUN),
        .cnt_o (cycle_count)
    );

    sat_counter #(.W(ADDR_W + 1), .MAX(LD_MAX)) u_ld_cnt (
        .clk   (clk1),
        .rst_n (rst_n),
        .clr_i (ld_acc && (state_q == ST_IDLE)),
        .en_i  (ld_acc),
        .cnt_o (load_count)
    );

endmodule
